// File: rtl/branch_decode_queue.sv
// Branch-class decoder (bc / b / bclr / bcctr / bctar) feeding a FifoDepth-entry
// valid/ready queue toward the branch unit, with saturating decoded/invalid counters.
module branch_decode_queue #(
  parameter int addressWidth            = 64,
  parameter int instructionWidth        = 32,
  parameter int PidSize                 = 20,
  parameter int TidSize                 = 16,
  parameter int instructionCounterWidth = 64,
  parameter int opcodeSize              = 12,
  parameter int funcUnitCodeSize        = 3,
  parameter int BranchUnitID            = 6,
  parameter int FifoDepth               = 2,
  parameter int countWidth              = 32
) (
  input  logic                               clock_i,
  input  logic                               reset_i,
  input  logic                               valid_i,
  output logic                               ready_o,
  input  logic [instructionWidth-1:0]        instruction_i,
  input  logic [addressWidth-1:0]            instructionAddress_i,
  input  logic                               is64Bit_i,
  input  logic [PidSize-1:0]                 instructionPid_i,
  input  logic [TidSize-1:0]                 instructionTid_i,
  input  logic [instructionCounterWidth-1:0] instructionMajId_i,
  output logic                               valid_o,
  input  logic                               ready_i,
  output logic [opcodeSize-1:0]              opcode_o,
  output logic [funcUnitCodeSize-1:0]        functionalUnitType_o,
  output logic [addressWidth-1:0]            instructionAddress_o,
  output logic [addressWidth-1:0]            targetAddress_o,
  output logic [1:0]                         tgtSrc_o,
  output logic [4:0]                         bo_o,
  output logic [4:0]                         bi_o,
  output logic [1:0]                         bh_o,
  output logic                               ctrDecrement_o,
  output logic                               lk_o,
  output logic [instructionCounterWidth-1:0] instMajId_o,
  output logic                               is64Bit_o,
  output logic [PidSize-1:0]                 instPid_o,
  output logic [TidSize-1:0]                 instTid_o,
  output logic [countWidth-1:0]              decodedCount_o,
  output logic [countWidth-1:0]              invalidCount_o
);

  localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int CntW = $clog2(FifoDepth + 1);

  typedef struct packed {
    logic [opcodeSize-1:0]              opcode;
    logic [funcUnitCodeSize-1:0]        fu;
    logic [addressWidth-1:0]            addr;
    logic [addressWidth-1:0]            target;
    logic [1:0]                         tgt_src;
    logic [4:0]                         bo;
    logic [4:0]                         bi;
    logic [1:0]                         bh;
    logic                               ctr_dec;
    logic                               lk;
    logic [instructionCounterWidth-1:0] maj_id;
    logic                               is64;
    logic [PidSize-1:0]                 pid;
    logic [TidSize-1:0]                 tid;
  } entry_t;

  function automatic logic [countWidth-1:0] sat_inc(input logic [countWidth-1:0] v);
    return (&v) ? v : v + countWidth'(1);
  endfunction

  // In 32-bit mode the architected upper word of a computed target is zero.
  function automatic logic [addressWidth-1:0] mode_mask(input logic [addressWidth-1:0] t,
                                                        input logic is64);
    logic [addressWidth-1:0] r;
    r = t;
    if (!is64) begin
      for (int i = 32; i < addressWidth; i++) r[i] = 1'b0;
    end
    return r;
  endfunction

  entry_t                 r_mem [FifoDepth];
  logic [PtrW-1:0]        r_wr;
  logic [PtrW-1:0]        r_rd;
  logic [CntW-1:0]        r_count;
  logic [countWidth-1:0]  r_decoded;
  logic [countWidth-1:0]  r_invalid;

  logic [5:0]                     w_prim;
  logic [9:0]                     w_xo;
  logic                           w_is_bc, w_is_b, w_is_bclr, w_is_bcctr, w_is_bctar, w_is_xl;
  logic                           w_valid_op;
  logic signed [addressWidth-1:0] w_ext;
  logic [addressWidth-1:0]        w_base;
  entry_t                         w_entry;
  entry_t                         w_head;
  logic                           w_accept, w_push, w_drop, w_pop;

  // Decode (instruction bit 0 is the MSB, so IBM field [a:b] sits at [31-a:31-b])
  assign w_prim     = instruction_i[31:26];
  assign w_xo       = instruction_i[10:1];
  assign w_is_bc    = (w_prim == 6'd16);
  assign w_is_b     = (w_prim == 6'd18);
  assign w_is_bclr  = (w_prim == 6'd19) && (w_xo == 10'd16);
  assign w_is_bcctr = (w_prim == 6'd19) && (w_xo == 10'd528);
  assign w_is_bctar = (w_prim == 6'd19) && (w_xo == 10'd560);
  assign w_is_xl    = w_is_bclr || w_is_bcctr || w_is_bctar;
  // bcctr that decrements CTR is an invalid form
  assign w_valid_op = w_is_bc || w_is_b || w_is_bclr || w_is_bctar
                      || (w_is_bcctr && instruction_i[23]);

  always_comb begin
    w_ext = '0;
    if (w_is_bc)
      w_ext = {{(addressWidth-16){instruction_i[15]}}, instruction_i[15:2], 2'b00};
    else if (w_is_b)
      w_ext = {{(addressWidth-26){instruction_i[25]}}, instruction_i[25:2], 2'b00};
  end

  assign w_base = instruction_i[1] ? '0 : instructionAddress_i;

  always_comb begin
    w_entry         = '0;
    w_entry.fu      = funcUnitCodeSize'(BranchUnitID);
    w_entry.addr    = instructionAddress_i;
    w_entry.lk      = instruction_i[0];
    w_entry.maj_id  = instructionMajId_i;
    w_entry.is64    = is64Bit_i;
    w_entry.pid     = instructionPid_i;
    w_entry.tid     = instructionTid_i;
    if (!w_is_b) begin
      w_entry.bo = instruction_i[25:21];
      w_entry.bi = instruction_i[20:16];
    end
    if (w_is_xl) w_entry.bh = instruction_i[12:11];
    if (w_is_bc || w_is_b)
      w_entry.target = mode_mask(w_base + $unsigned(w_ext), is64Bit_i);
    w_entry.ctr_dec = (w_is_bc || w_is_bclr || w_is_bctar) && !instruction_i[23];
    if (w_is_bc)         begin w_entry.opcode = opcodeSize'(24); w_entry.tgt_src = 2'd0; end
    else if (w_is_b)     begin w_entry.opcode = opcodeSize'(25); w_entry.tgt_src = 2'd0; end
    else if (w_is_bclr)  begin w_entry.opcode = opcodeSize'(26); w_entry.tgt_src = 2'd1; end
    else if (w_is_bcctr) begin w_entry.opcode = opcodeSize'(27); w_entry.tgt_src = 2'd2; end
    else if (w_is_bctar) begin w_entry.opcode = opcodeSize'(28); w_entry.tgt_src = 2'd3; end
  end

  // Queue handshake; full blocks input even when the head is popped this cycle
  assign ready_o  = (r_count != CntW'(FifoDepth));
  assign valid_o  = (r_count != '0);
  assign w_accept = valid_i && ready_o;
  assign w_push   = w_accept && w_valid_op;
  assign w_drop   = w_accept && !w_valid_op;
  assign w_pop    = valid_o && ready_i;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_count   <= '0;
      r_wr      <= '0;
      r_rd      <= '0;
      r_decoded <= '0;
      r_invalid <= '0;
      for (int i = 0; i < FifoDepth; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= w_entry;
        r_wr        <= r_wr + PtrW'(1);
        r_decoded   <= sat_inc(r_decoded);
      end
      if (w_drop) r_invalid <= sat_inc(r_invalid);
      if (w_pop)  r_rd <= r_rd + PtrW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CntW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CntW'(1);
    end
  end

  // Head entry drives the output bus
  assign w_head               = r_mem[r_rd];
  assign opcode_o             = w_head.opcode;
  assign functionalUnitType_o = w_head.fu;
  assign instructionAddress_o = w_head.addr;
  assign targetAddress_o      = w_head.target;
  assign tgtSrc_o             = w_head.tgt_src;
  assign bo_o                 = w_head.bo;
  assign bi_o                 = w_head.bi;
  assign bh_o                 = w_head.bh;
  assign ctrDecrement_o       = w_head.ctr_dec;
  assign lk_o                 = w_head.lk;
  assign instMajId_o          = w_head.maj_id;
  assign is64Bit_o            = w_head.is64;
  assign instPid_o            = w_head.pid;
  assign instTid_o            = w_head.tid;
  assign decodedCount_o       = r_decoded;
  assign invalidCount_o       = r_invalid;

endmodule

// File: tb/tb_branch_decode_queue.sv
// Bench for branch_decode_queue: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the decoder.
module tb_branch_decode_queue;

  localparam int DEPTH = 2;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] instruction_i;
  logic [63:0] instructionAddress_i;
  logic        is64Bit_i;
  logic [19:0] instructionPid_i;
  logic [15:0] instructionTid_i;
  logic [63:0] instructionMajId_i;
  logic        valid_o;
  logic        ready_i;
  logic [11:0] opcode_o;
  logic [2:0]  functionalUnitType_o;
  logic [63:0] instructionAddress_o;
  logic [63:0] targetAddress_o;
  logic [1:0]  tgtSrc_o;
  logic [4:0]  bo_o;
  logic [4:0]  bi_o;
  logic [1:0]  bh_o;
  logic        ctrDecrement_o;
  logic        lk_o;
  logic [63:0] instMajId_o;
  logic        is64Bit_o;
  logic [19:0] instPid_o;
  logic [15:0] instTid_o;
  logic [31:0] decodedCount_o;
  logic [31:0] invalidCount_o;

  branch_decode_queue dut (
    .clock_i(clock_i), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready_o),
    .instruction_i(instruction_i), .instructionAddress_i(instructionAddress_i),
    .is64Bit_i(is64Bit_i), .instructionPid_i(instructionPid_i),
    .instructionTid_i(instructionTid_i), .instructionMajId_i(instructionMajId_i),
    .valid_o(valid_o), .ready_i(ready_i), .opcode_o(opcode_o),
    .functionalUnitType_o(functionalUnitType_o), .instructionAddress_o(instructionAddress_o),
    .targetAddress_o(targetAddress_o), .tgtSrc_o(tgtSrc_o), .bo_o(bo_o), .bi_o(bi_o),
    .bh_o(bh_o), .ctrDecrement_o(ctrDecrement_o), .lk_o(lk_o), .instMajId_o(instMajId_o),
    .is64Bit_o(is64Bit_o), .instPid_o(instPid_o), .instTid_o(instTid_o),
    .decodedCount_o(decodedCount_o), .invalidCount_o(invalidCount_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct {
    bit          ok;
    logic [11:0] opc;
    logic [63:0] addr;
    logic [63:0] tgt;
    logic [1:0]  src;
    logic [4:0]  bo;
    logic [4:0]  bi;
    logic [1:0]  bh;
    logic        ctr;
    logic        lk;
    logic [63:0] maj;
    logic        is64;
    logic [19:0] pid;
    logic [15:0] tid;
  } exp_t;

  exp_t q[$];
  int   mdec, minv;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference decode written from the architectural field definitions.
  function automatic exp_t model_decode(logic [31:0] inst, logic [63:0] addr, logic is64,
                                        logic [63:0] maj, logic [19:0] pid, logic [15:0] tid);
    exp_t e;
    int unsigned prim, xo, bo, bi;
    longint ext;
    logic [63:0] base;
    prim = inst >> 26;
    xo   = (inst >> 1) & 32'h3FF;
    bo   = (inst >> 21) & 32'h1F;
    bi   = (inst >> 16) & 32'h1F;
    e.ok = 1; e.addr = addr; e.maj = maj; e.is64 = is64; e.pid = pid; e.tid = tid;
    e.lk = inst & 1; e.tgt = 0; e.bh = 0; e.bo = 5'(bo); e.bi = 5'(bi); e.ctr = 0; e.src = 0;
    base = ((inst >> 1) & 1) ? 64'd0 : addr;
    if (prim == 16) begin
      ext = longint'((inst >> 2) & 32'h3FFF);
      if (ext >= 8192) ext -= 16384;
      e.opc = 24; e.tgt = base + 64'(ext * 4); e.ctr = ((bo >> 2) & 1) == 0;
    end else if (prim == 18) begin
      ext = longint'((inst >> 2) & 32'hFFFFFF);
      if (ext >= 64'd8388608) ext -= 16777216;
      e.opc = 25; e.tgt = base + 64'(ext * 4); e.bo = 0; e.bi = 0;
    end else if (prim == 19 && (xo == 16 || xo == 528 || xo == 560)) begin
      e.bh = 2'((inst >> 11) & 3);
      if (xo == 16)       begin e.opc = 26; e.src = 1; e.ctr = ((bo >> 2) & 1) == 0; end
      else if (xo == 528) begin e.opc = 27; e.src = 2; e.ok = ((bo >> 2) & 1) == 1; end
      else                begin e.opc = 28; e.src = 3; e.ctr = ((bo >> 2) & 1) == 0; end
    end else begin
      e.ok = 0; e.opc = 0;
    end
    if (!is64) e.tgt = e.tgt & 64'h0000_0000_FFFF_FFFF;
    return e;
  endfunction

  function automatic logic [278:0] pack_exp(exp_t e);
    return {e.opc, 3'd6, e.addr, e.tgt, e.src, e.bo, e.bi, e.bh, e.ctr, e.lk,
            e.maj, e.is64, e.pid, e.tid};
  endfunction

  function automatic logic [278:0] pack_dut();
    return {opcode_o, functionalUnitType_o, instructionAddress_o, targetAddress_o, tgtSrc_o,
            bo_o, bi_o, bh_o, ctrDecrement_o, lk_o, instMajId_o, is64Bit_o, instPid_o, instTid_o};
  endfunction

  task automatic do_reset();
    reset_i = 1; valid_i = 0; ready_i = 0;
    @(posedge clock_i); @(negedge clock_i);
    reset_i = 0;
    q.delete(); mdec = 0; minv = 0;
  endtask

  // One clock: drive inputs at the falling edge, check against the model, advance.
  task automatic cycle(input bit vin, input logic [31:0] inst, input logic [63:0] addr,
                       input bit is64, input logic [63:0] maj, input bit rdy);
    exp_t e;
    bit acc, pop;
    valid_i = vin; instruction_i = inst; instructionAddress_i = addr; is64Bit_i = is64;
    instructionMajId_i = maj; instructionPid_i = 20'($urandom); instructionTid_i = 16'($urandom);
    ready_i = rdy;
    #1;
    n_tests++;
    if (ready_o !== (q.size() != DEPTH)) begin
      n_fail++; $display("FAIL ready_o: got %0b expected %0b", ready_o, q.size() != DEPTH);
    end
    n_tests++;
    if (valid_o !== (q.size() != 0)) begin
      n_fail++; $display("FAIL valid_o: got %0b expected %0b", valid_o, q.size() != 0);
    end
    n_tests++;
    if (decodedCount_o !== 32'(mdec) || invalidCount_o !== 32'(minv)) begin
      n_fail++;
      $display("FAIL counters: got dec=%0d inv=%0d expected dec=%0d inv=%0d",
               decodedCount_o, invalidCount_o, mdec, minv);
    end
    if (q.size() != 0) begin
      n_tests++;
      if (pack_dut() !== pack_exp(q[0])) begin
        n_fail++; $display("FAIL head: got %h expected %h", pack_dut(), pack_exp(q[0]));
      end
    end
    acc = vin && (q.size() != DEPTH);
    pop = (q.size() != 0) && rdy;
    e = model_decode(inst, addr, is64, maj, instructionPid_i, instructionTid_i);
    if (pop) void'(q.pop_front());
    if (acc) begin
      if (e.ok) begin q.push_back(e); mdec++; end
      else minv++;
    end
    @(posedge clock_i); @(negedge clock_i);
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_hs: got valid=%0b ready=%0b expected 0 1", valid_o, ready_o);
    end
    n_tests++;
    if (pack_dut() !== '0 || decodedCount_o !== 0 || invalidCount_o !== 0) begin
      n_fail++; $display("FAIL reset_data: got %h dec=%0d inv=%0d expected all 0",
                         pack_dut(), decodedCount_o, invalidCount_o);
    end
  endtask

  task automatic test_bc();
    cycle(1, 32'h4182FFFC, 64'h1000, 1, 64'd11, 0);
    n_tests++;
    if (valid_o !== 1 || opcode_o !== 12'd24 || targetAddress_o !== 64'h0FFC || bo_o !== 5'd12
        || bi_o !== 5'd2 || ctrDecrement_o !== 0 || tgtSrc_o !== 0) begin
      n_fail++; $display("FAIL bc: got v=%0b op=%0d tgt=%h bo=%0d bi=%0d ctr=%0b src=%0d expected 1 24 0ffc 12 2 0 0",
                         valid_o, opcode_o, targetAddress_o, bo_o, bi_o, ctrDecrement_o, tgtSrc_o);
    end
    cycle(0, 0, 0, 1, 0, 1);
  endtask

  task automatic test_b_abs();
    cycle(1, 32'h48000103, 64'h5000, 1, 64'd12, 0);
    n_tests++;
    if (opcode_o !== 12'd25 || targetAddress_o !== 64'h100 || lk_o !== 1 || bo_o !== 0 || bi_o !== 0) begin
      n_fail++; $display("FAIL b_abs: got op=%0d tgt=%h lk=%0b bo=%0d bi=%0d expected 25 100 1 0 0",
                         opcode_o, targetAddress_o, lk_o, bo_o, bi_o);
    end
    cycle(0, 0, 0, 1, 0, 1);
  endtask

  task automatic test_b_32bit();
    cycle(1, 32'h48000008, 64'hFFFF_FFFC, 0, 64'd13, 0);
    n_tests++;
    if (targetAddress_o !== 64'h4) begin
      n_fail++; $display("FAIL b_32bit: got tgt=%h expected 0000000000000004", targetAddress_o);
    end
    cycle(0, 0, 0, 1, 0, 1);
  endtask

  task automatic test_backpressure();
    cycle(1, 32'h4182FFFC, 64'h2000, 1, 64'd1, 0);
    cycle(1, 32'h48000103, 64'h2004, 1, 64'd2, 0);
    n_tests++;
    if (ready_o !== 0) begin
      n_fail++; $display("FAIL full_ready: got %0b expected 0", ready_o);
    end
    cycle(1, 32'h48000008, 64'h2008, 1, 64'd3, 0);
    n_tests++;
    if (decodedCount_o !== 32'(mdec) || instMajId_o !== 64'd1) begin
      n_fail++; $display("FAIL ignored_push: got dec=%0d head=%0d expected %0d 1",
                         decodedCount_o, instMajId_o, mdec);
    end
    cycle(0, 0, 0, 1, 0, 1);
    n_tests++;
    if (instMajId_o !== 64'd2 || valid_o !== 1) begin
      n_fail++; $display("FAIL drain_order: got head=%0d v=%0b expected 2 1", instMajId_o, valid_o);
    end
    cycle(0, 0, 0, 1, 0, 1);
    n_tests++;
    if (valid_o !== 0 || ready_o !== 1) begin
      n_fail++; $display("FAIL drained: got v=%0b r=%0b expected 0 1", valid_o, ready_o);
    end
  endtask

  task automatic test_invalid();
    int inv0, dec0;
    inv0 = minv; dec0 = mdec;
    cycle(1, 32'h4C000000, 64'h3000, 1, 64'd21, 0);
    cycle(1, 32'h4C000420, 64'h3004, 1, 64'd22, 0);
    n_tests++;
    if (valid_o !== 0 || invalidCount_o !== 32'(inv0 + 2) || decodedCount_o !== 32'(dec0)) begin
      n_fail++; $display("FAIL invalid: got v=%0b inv=%0d dec=%0d expected 0 %0d %0d",
                         valid_o, invalidCount_o, decodedCount_o, inv0 + 2, dec0);
    end
  endtask

  task automatic test_reset_mid();
    cycle(1, 32'h4182FFFC, 64'h4000, 1, 64'd31, 0);
    cycle(1, 32'h4182FFFC, 64'h4004, 1, 64'd32, 0);
    do_reset();
    n_tests++;
    if (valid_o !== 0 || ready_o !== 1 || decodedCount_o !== 0 || invalidCount_o !== 0) begin
      n_fail++; $display("FAIL reset_mid: got v=%0b r=%0b dec=%0d inv=%0d expected 0 1 0 0",
                         valid_o, ready_o, decodedCount_o, invalidCount_o);
    end
    cycle(1, 32'h48000103, 64'h4008, 1, 64'd33, 0);
    cycle(0, 0, 0, 1, 0, 1);
    n_tests++;
    if (valid_o !== 0) begin
      n_fail++; $display("FAIL reset_alone: got v=%0b expected 0", valid_o);
    end
  endtask

  task automatic test_random();
    logic [31:0] inst;
    logic [63:0] addr;
    for (int i = 0; i < 600; i++) begin
      inst = $urandom;
      case ($urandom_range(0, 7))
        0: inst[31:26] = 6'd16;
        1: inst[31:26] = 6'd18;
        2: begin inst[31:26] = 6'd19; inst[10:1] = 10'd16;  end
        3: begin inst[31:26] = 6'd19; inst[10:1] = 10'd528; end
        4: begin inst[31:26] = 6'd19; inst[10:1] = 10'd560; end
        5: if (inst[31:26] == 6'd16 || inst[31:26] == 6'd18 || inst[31:26] == 6'd19) inst[31:26] = 6'd31;
        6: begin
             inst[31:26] = 6'd19;
             if (inst[10:1] == 10'd16 || inst[10:1] == 10'd528 || inst[10:1] == 10'd560) inst[10:1] = 10'd0;
           end
        default: begin inst[31:26] = 6'd19; inst[10:1] = 10'd528; inst[23] = 1'b0; end
      endcase
      addr = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) addr = {32'h0, 30'h3FFFFFFF, 2'b00} - 64'($urandom_range(0, 64));
      cycle($urandom_range(0, 3) != 0, inst, addr, $urandom_range(0, 1), 64'(i + 100),
            $urandom_range(0, 2) != 0);
    end
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 0, 1);
  endtask

  initial begin
    reset_i = 1; valid_i = 0; ready_i = 0; instruction_i = 0; instructionAddress_i = 0;
    is64Bit_i = 1; instructionPid_i = 0; instructionTid_i = 0; instructionMajId_i = 0;
    @(negedge clock_i);
    test_reset();
    test_bc();
    test_b_abs();
    test_b_32bit();
    test_backpressure();
    test_invalid();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
